router_fifo: RTL and testbench

- One of three identical output buffers in the 1x3 router, directly downstream of the synchroniser.
- Accepts bytes while its write_enb bit from the synchroniser is high, and reports full/empty back to the synchroniser.
- Is cleared by that output's soft_reset.
- Tags each stored byte with a header flag (lfd_state from the FSM) so the read side can track packet length and know when a packet has been fully drained.

---
 rtl/router_fifo_if.sv | 17 +
 rtl/router_fifo.sv | 64 ++++++
 tb/tb_router_fifo.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/router_fifo_if.sv
// Write/read handshake bundle between the synchroniser/destination (master)
// and one router output buffer (slave).
interface router_fifo_if #(parameter int WIDTH = 8);
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             pkt_busy;

  modport master (output write_enb, read_enb, lfd_state, data_in,
                  input  data_out, full, empty, pkt_busy);
  modport slave  (input  write_enb, read_enb, lfd_state, data_in,
                  output data_out, full, empty, pkt_busy);
endinterface

// File: rtl/router_fifo.sv
// One 1x3-router output buffer: header-tagged FIFO with read-side packet
// length tracking so the destination can see when a packet has drained.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int PTR_W = 4
) (
  input logic         clock,
  input logic         resetn,
  input logic         soft_reset,
  router_fifo_if.slave bus
);
  logic [WIDTH:0]   mem [DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [6:0]       cnt;
  logic [WIDTH-1:0] data_out_q;
  logic             full, empty, wr_ok, rd_ok;
  logic [WIDTH:0]   rd_word;
  logic [6:0]       hdr_len;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign wr_ok   = bus.write_enb && !full;
  assign rd_ok   = bus.read_enb && !empty;
  assign rd_word = mem[rd_ptr[PTR_W-1:0]];
  // Header carries payload length in [7:2]; +1 accounts for the parity byte.
  assign hdr_len = 7'(rd_word[WIDTH-1:2]) + 7'd1;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.data_out = data_out_q;
  assign bus.pkt_busy = (cnt != 7'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      data_out_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (soft_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      data_out_q <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr[PTR_W-1:0]] <= {bus.lfd_state, bus.data_in};
        wr_ptr                 <= wr_ptr + (PTR_W+1)'(1);
      end
      if (rd_ok) begin
        data_out_q <= rd_word[WIDTH-1:0];
        rd_ptr     <= rd_ptr + (PTR_W+1)'(1);
        if (rd_word[WIDTH])      cnt <= hdr_len;
        else if (cnt != 7'd0)    cnt <= cnt - 7'd1;
      end else if (cnt == 7'd0) begin
        // Line idles at zero once the packet (or orphan byte) has gone out.
        data_out_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: vector table for one packet plus
// hand-written multi-cycle corner-case sequences.
module tb_router_fifo;
  logic clock = 1'b0;
  logic resetn, soft_reset;
  int   checks = 0, errors = 0;

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo #(.DEPTH(16), .WIDTH(8), .PTR_W(4)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset), .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       we, re, lfd;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_full, exp_empty, exp_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic re, input logic lfd, input logic [7:0] din);
    bus.write_enb = we;
    bus.read_enb  = re;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_flags(input string nm, input int f, input int e, input int b);
    chk({nm, ".full"},  int'(bus.full),     f);
    chk({nm, ".empty"}, int'(bus.empty),    e);
    chk({nm, ".busy"},  int'(bus.pkt_busy), b);
  endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0;
    bus.write_enb = 1'b0; bus.read_enb = 1'b0; bus.lfd_state = 1'b0; bus.data_in = '0;
    #3;
    chk("por.dout", int'(bus.data_out), 0);
    chk_flags("por", 0, 1, 0);
    #5 resetn = 1'b1;   // t=8, between edges

    // Single packet: header 0E (len 3), payload A1..A3, parity 5C.
    //          we   re   lfd  din    dout   full empty busy
    vecs[0]  = '{1'b1,1'b0,1'b1,8'h0E, 8'h00, 1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b0,8'hA1, 8'h00, 1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0,8'hA2, 8'h00, 1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b0,1'b0,8'hA3, 8'h00, 1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b0,8'h5C, 8'h00, 1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0,8'h00, 8'h0E, 1'b0,1'b0,1'b1};
    vecs[6]  = '{1'b0,1'b1,1'b0,8'h00, 8'hA1, 1'b0,1'b0,1'b1};
    vecs[7]  = '{1'b0,1'b1,1'b0,8'h00, 8'hA2, 1'b0,1'b0,1'b1};
    vecs[8]  = '{1'b0,1'b1,1'b0,8'h00, 8'hA3, 1'b0,1'b0,1'b1};
    vecs[9]  = '{1'b0,1'b1,1'b0,8'h00, 8'h5C, 1'b0,1'b1,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,8'h00, 8'h00, 1'b0,1'b1,1'b0};
    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].we, vecs[i].re, vecs[i].lfd, vecs[i].din);
      chk($sformatf("pkt[%0d].dout", i), int'(bus.data_out), int'(vecs[i].exp_dout));
      chk_flags($sformatf("pkt[%0d]", i), int'(vecs[i].exp_full),
                int'(vecs[i].exp_empty), int'(vecs[i].exp_busy));
    end

    // Fill to full, drop a 17th write, drain in order.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(i*3 + 1));
      chk($sformatf("fill[%0d].full", i), int'(bus.full), (i == 15) ? 1 : 0);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'hFF);
    chk("fill.drop.full", int'(bus.full), 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("drain[%0d].dout", i), int'(bus.data_out), i*3 + 1);
    end
    chk_flags("drain.end", 0, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("drain.idle.dout", int'(bus.data_out), 0);

    // Full with simultaneous read/write: read taken, write dropped.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    chk("rw_full.pre.full", int'(bus.full), 1);
    cyc(1'b1, 1'b1, 1'b0, 8'hEE);
    chk("rw_full.dout", int'(bus.data_out), 8'h40);
    chk_flags("rw_full", 0, 0, 0);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("rw_full.rd[%0d]", i), int'(bus.data_out), 8'h40 + i);
    end
    chk("rw_full.end.empty", int'(bus.empty), 1);

    // Eight stored, three cycles of read+write: occupancy steady, order kept.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'(8'h70 + k));
      chk($sformatf("rw8.both[%0d]", k), int'(bus.data_out), 8'h60 + k);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("rw8.rd[%0d]", i), int'(bus.data_out),
          (i < 5) ? (8'h63 + i) : (8'h70 + i - 5));
      chk($sformatf("rw8.rd[%0d].empty", i), int'(bus.empty), (i == 7) ? 1 : 0);
    end

    // Wrap-around: 12 in/out, then 10 in/out across the pointer wrap.
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
    chk_flags("wrap.w12", 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("wrap.r12[%0d]", i), int'(bus.data_out), 8'h80 + i);
    end
    chk_flags("wrap.r12", 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
    chk_flags("wrap.w10", 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("wrap.r10[%0d]", i), int'(bus.data_out), 8'hA0 + i);
    end
    chk_flags("wrap.r10", 0, 1, 0);

    // Soft reset mid-packet: header 14 gives cnt 6, then flush with a write.
    cyc(1'b1, 1'b0, 1'b1, 8'h14);
    cyc(1'b1, 1'b0, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 1'b0, 8'h22);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("srst.hdr.dout", int'(bus.data_out), 8'h14);
    chk("srst.hdr.busy", int'(bus.pkt_busy), 1);
    soft_reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 8'h99);
    soft_reset = 1'b0;
    chk("srst.dout", int'(bus.data_out), 0);
    chk_flags("srst", 0, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("srst.after.empty", int'(bus.empty), 1);

    // Asynchronous reset with five words stored and non-zero data_out.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("arst.pre.dout", int'(bus.data_out), 8'hC0);
    #2 resetn = 1'b0;
    #1;
    chk("arst.dout", int'(bus.data_out), 0);
    chk_flags("arst", 0, 1, 0);
    #3 resetn = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("arst.after.empty", int'(bus.empty), 1);
    chk("arst.after.dout", int'(bus.data_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
